// File: rtl/ex_mdu_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: M-extension encodings,
// MDU state encoding and small func3 decode helpers.
package ex_mdu_pkg;

  localparam logic [6:0] INST_FUNC7_M = 7'b0000001;

  localparam logic [2:0] INST_MUL    = 3'd0;
  localparam logic [2:0] INST_MULH   = 3'd1;
  localparam logic [2:0] INST_MULHSU = 3'd2;
  localparam logic [2:0] INST_MULHU  = 3'd3;
  localparam logic [2:0] INST_DIV    = 3'd4;
  localparam logic [2:0] INST_DIVU   = 3'd5;
  localparam logic [2:0] INST_REM    = 3'd6;
  localparam logic [2:0] INST_REMU   = 3'd7;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_CALC = 2'd1,
    MDU_DONE = 2'd2
  } mdu_state_e;

  function automatic logic op_is_div(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic op_is_rem(input logic [2:0] op);
    return op[2] & op[1];
  endfunction

  function automatic logic op_rs1_signed(input logic [2:0] op);
    return (op == INST_MULH) || (op == INST_MULHSU) || (op == INST_DIV) || (op == INST_REM);
  endfunction

  function automatic logic op_rs2_signed(input logic [2:0] op);
    return (op == INST_MULH) || (op == INST_DIV) || (op == INST_REM);
  endfunction

endpackage

// File: rtl/mdu_div_iter.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor and emit one quotient bit.
module mdu_div_iter #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN:0]   rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN:0]   rem_next,
  output logic [XLEN-1:0] quo_next
);

  logic [XLEN+1:0] shifted;
  logic [XLEN+1:0] diff;

  // A borrow out of the trial subtraction means the divisor did not fit: restore.
  always_comb begin
    shifted = {rem, quo[XLEN-1]};
    diff    = shifted - (XLEN+2)'(divisor);
    if (diff[XLEN+1]) begin
      rem_next = shifted[XLEN:0];
      quo_next = {quo[XLEN-2:0], 1'b0};
    end else begin
      rem_next = diff[XLEN:0];
      quo_next = {quo[XLEN-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/ex_mdu.sv
// Multi-cycle RV32M multiply/divide unit beside the EX ALU: stalls the pipeline
// while iterating on operand magnitudes, then writes rd for a single cycle.
module ex_mdu
  import ex_mdu_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned MUL_FAST = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic [4:0]      rd_addr_i,
  input  logic            flush_i,
  output logic            hold_flag_o,
  output logic            busy_o,
  output logic [4:0]      rd_addr_o,
  output logic [XLEN-1:0] rd_data_o,
  output logic            rd_wr_en_o
);

  localparam int unsigned CNT_W = $clog2(XLEN);
  localparam int unsigned PW    = 2 * XLEN;

  mdu_state_e      state;
  logic [2:0]      op_q;
  logic            neg_q;
  logic            neg_rem_q;
  logic [XLEN:0]   rem_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] opb_q;
  logic [CNT_W-1:0] cnt_q;
  logic            wr_en_q;
  logic [XLEN-1:0] rd_data_q;
  logic [4:0]      rd_addr_q;

  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] mag_a;
  logic [XLEN-1:0] mag_b;
  logic            div_zero;
  logic            div_ovf;
  logic            special;
  logic [XLEN-1:0] special_res;
  logic [PW-1:0]   fast_prod;
  logic [XLEN-1:0] fast_res;

  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_rem;
  logic [XLEN-1:0] div_quo;
  logic [XLEN:0]   rem_n;
  logic [XLEN-1:0] quo_n;
  logic            last;
  logic [XLEN-1:0] final_res;

  // hi/lo hold the product halves for MUL*, remainder/quotient for DIV*.
  function automatic logic [XLEN-1:0] fix_result(
    input logic [2:0]      op,
    input logic            neg_main,
    input logic            neg_rem,
    input logic [XLEN-1:0] hi,
    input logic [XLEN-1:0] lo
  );
    logic [PW-1:0] prod;
    prod = {hi, lo};
    if (neg_main) prod = PW'(0) - prod;
    if (!op_is_div(op)) return (op == INST_MUL) ? prod[XLEN-1:0] : prod[PW-1:XLEN];
    if (op_is_rem(op)) return neg_rem ? XLEN'(0) - hi : hi;
    return neg_main ? XLEN'(0) - lo : lo;
  endfunction

  // Issue-time decode: sign flags, magnitudes and the division corner cases.
  always_comb begin
    a_neg    = op_rs1_signed(op_i) & rs1_data_i[XLEN-1];
    b_neg    = op_rs2_signed(op_i) & rs2_data_i[XLEN-1];
    mag_a    = a_neg ? XLEN'(0) - rs1_data_i : rs1_data_i;
    mag_b    = b_neg ? XLEN'(0) - rs2_data_i : rs2_data_i;
    div_zero = (rs2_data_i == '0);
    div_ovf  = op_rs2_signed(op_i) & (rs1_data_i == {1'b1, {(XLEN-1){1'b0}}}) &
               (rs2_data_i == '1);
    special  = op_is_div(op_i) & (div_zero | div_ovf);
    if (op_is_rem(op_i)) special_res = div_zero ? rs1_data_i : '0;
    else                 special_res = div_zero ? '1 : rs1_data_i;
    fast_prod = PW'(mag_a) * PW'(mag_b);
    fast_res  = fix_result(op_i, a_neg ^ b_neg, 1'b0, fast_prod[PW-1:XLEN],
                           fast_prod[XLEN-1:0]);
  end

  mdu_div_iter #(
    .XLEN(XLEN)
  ) u_div_iter (
    .rem      (rem_q),
    .quo      (quo_q),
    .divisor  (opb_q),
    .rem_next (div_rem),
    .quo_next (div_quo)
  );

  // Shift-add multiply keeps the product high half in rem_q and the low half
  // (initially the multiplier) in quo_q, shifting right one bit per cycle.
  always_comb begin
    mul_sum = {1'b0, rem_q[XLEN-1:0]} + (quo_q[0] ? {1'b0, opb_q} : (XLEN+1)'(0));
    if (op_is_div(op_q)) begin
      rem_n = div_rem;
      quo_n = div_quo;
    end else begin
      rem_n = {1'b0, mul_sum[XLEN:1]};
      quo_n = {mul_sum[0], quo_q[XLEN-1:1]};
    end
    last      = (cnt_q == CNT_W'(XLEN - 1));
    final_res = fix_result(op_q, neg_q, neg_rem_q, rem_n[XLEN-1:0], quo_n);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= MDU_IDLE;
      op_q      <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      rem_q     <= '0;
      quo_q     <= '0;
      opb_q     <= '0;
      cnt_q     <= '0;
      wr_en_q   <= 1'b0;
      rd_data_q <= '0;
      rd_addr_q <= '0;
    end else if (flush_i) begin
      state     <= MDU_IDLE;
      wr_en_q   <= 1'b0;
      rd_data_q <= '0;
    end else begin
      case (state)
        MDU_IDLE: begin
          if (start_i) begin
            op_q      <= op_i;
            rd_addr_q <= rd_addr_i;
            neg_q     <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            rem_q     <= '0;
            cnt_q     <= '0;
            quo_q     <= op_is_div(op_i) ? mag_a : mag_b;
            opb_q     <= op_is_div(op_i) ? mag_b : mag_a;
            if (special) begin
              rd_data_q <= special_res;
              wr_en_q   <= 1'b1;
              state     <= MDU_DONE;
            end else if ((MUL_FAST != 0) && !op_is_div(op_i)) begin
              rd_data_q <= fast_res;
              wr_en_q   <= 1'b1;
              state     <= MDU_DONE;
            end else begin
              state <= MDU_CALC;
            end
          end
        end
        MDU_CALC: begin
          rem_q <= rem_n;
          quo_q <= quo_n;
          cnt_q <= cnt_q + CNT_W'(1);
          if (last) begin
            rd_data_q <= final_res;
            wr_en_q   <= 1'b1;
            state     <= MDU_DONE;
          end
        end
        MDU_DONE: begin
          wr_en_q   <= 1'b0;
          rd_data_q <= '0;
          state     <= MDU_IDLE;
        end
        default: state <= MDU_IDLE;
      endcase
    end
  end

  // The stall covers the issue cycle itself; a flush kills a write already in DONE.
  assign hold_flag_o = ((state == MDU_IDLE) & start_i & ~flush_i) | (state == MDU_CALC);
  assign busy_o      = (state != MDU_IDLE);
  assign rd_wr_en_o  = wr_en_q & ~flush_i;
  assign rd_data_o   = rd_data_q;
  assign rd_addr_o   = rd_addr_q;

endmodule

// File: tb/tb_ex_mdu.sv
// Randomized scoreboard bench for ex_mdu: a 32-bit iterative instance checked
// against plain 64-bit arithmetic, plus a 16-bit fast-multiply instance.
module tb_ex_mdu;

  localparam int unsigned XLEN = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [2:0]  op_i;
  logic [31:0] rs1_data_i;
  logic [31:0] rs2_data_i;
  logic [4:0]  rd_addr_i;
  logic        flush_i;
  logic        hold_flag_o;
  logic        busy_o;
  logic [4:0]  rd_addr_o;
  logic [31:0] rd_data_o;
  logic        rd_wr_en_o;

  logic        start16;
  logic [2:0]  op16;
  logic [15:0] a16;
  logic [15:0] b16;
  logic [4:0]  rd16;
  logic        flush16;
  logic        hold16;
  logic        busy16;
  logic [4:0]  rdaddr16;
  logic [15:0] rddata16;
  logic        wr16;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  addr;
    int          due;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  ex_mdu #(.XLEN(32), .MUL_FAST(0)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i),
    .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .rd_addr_i(rd_addr_i),
    .flush_i(flush_i), .hold_flag_o(hold_flag_o), .busy_o(busy_o),
    .rd_addr_o(rd_addr_o), .rd_data_o(rd_data_o), .rd_wr_en_o(rd_wr_en_o)
  );

  ex_mdu #(.XLEN(16), .MUL_FAST(1)) dut16 (
    .clk(clk), .rst(rst), .start_i(start16), .op_i(op16),
    .rs1_data_i(a16), .rs2_data_i(b16), .rd_addr_i(rd16),
    .flush_i(flush16), .hold_flag_o(hold16), .busy_o(busy16),
    .rd_addr_o(rdaddr16), .rd_data_o(rddata16), .rd_wr_en_o(wr16)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // RV32M semantics computed with 64-bit integer arithmetic.
  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb, ub_s;
    longint unsigned ua, ub;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = 64'(a);
    ub = 64'(b);
    ub_s = longint'(ub);
    r = '0;
    case (op)
      3'd0: r = ua * ub;
      3'd1: r = 64'(sa * sb) >> 32;
      3'd2: r = 64'(sa * ub_s) >> 32;
      3'd3: r = (ua * ub) >> 32;
      3'd4: r = (b == 0) ? '1 : 64'(sa / sb);
      3'd5: r = (b == 0) ? '1 : ua / ub;
      3'd6: r = (b == 0) ? 64'(a) : 64'(sa % sb);
      default: r = (b == 0) ? 64'(a) : ua % ub;
    endcase
    return r[31:0];
  endfunction

  function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
    if (op >= 3'd4 && b == 0) return 1;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return XLEN + 1;
  endfunction

  function automatic logic [15:0] ref16(input logic [2:0] op, input logic [15:0] a,
                                        input logic [15:0] b);
    longint sa, sb, ub;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({16'h0, b});
    case (op)
      3'd1:    r = 64'(sa * sb) >> 16;
      3'd2:    r = 64'(sa * ub) >> 16;
      3'd3:    r = 64'(longint'({16'h0, a}) * ub) >> 16;
      default: r = 64'(longint'({16'h0, a}) * ub);
    endcase
    return r[15:0];
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  // Monitor: every write must match the oldest expectation in value, rd and cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst) continue;
      if (rd_wr_en_o) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_write: got rd_data %h rd %0d, required no write", rd_data_o, rd_addr_o);
        end else begin
          e = exp_q.pop_front();
          check("rd_data", rd_data_o, e.data);
          check("rd_addr", 32'(rd_addr_o), 32'(e.addr));
          check("write_cycle", 32'(cyc), 32'(e.due));
        end
      end else begin
        if (!flush_i) check("rd_data_idle", rd_data_o, 32'h0);
        if (exp_q.size() > 0 && cyc > exp_q[0].due) begin
          n_checks++;
          $display("FAIL missing_write: got none by cycle %0d, required %h at %0d", cyc, exp_q[0].data, exp_q[0].due);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // Issue one op; optionally flush, reset or re-pulse start at a cycle offset.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input int flush_at, input int rst_at,
                       input int poke_at);
    int n0, hc, lat, full_hc, exp_hc, abort_at;
    bit aborted, finished;
    exp_t e;
    lat = ref_latency(op, a, b);
    aborted = (flush_at >= 0) || (rst_at >= 0);
    abort_at = (flush_at >= 0) ? flush_at : rst_at;
    full_hc = (lat == 1) ? 1 : XLEN + 1;
    exp_hc = (aborted && abort_at + 1 < full_hc) ? abort_at + 1 : full_hc;
    n0 = cyc;
    if (!aborted) begin
      e.data = ref_result(op, a, b);
      e.addr = rd;
      e.due  = n0 + lat;
      exp_q.push_back(e);
    end
    start_i = 1'b1; op_i = op; rs1_data_i = a; rs2_data_i = b; rd_addr_i = rd;
    hc = 0;
    finished = 1'b0;
    #1;
    if (hold_flag_o) hc++;
    for (int k = 1; k <= int'(XLEN) + 4; k++) begin
      @(negedge clk);
      start_i = (k == poke_at);
      if (k == poke_at) begin
        op_i = 3'($urandom); rs1_data_i = $urandom; rs2_data_i = $urandom; rd_addr_i = 5'($urandom);
      end
      flush_i = (k == flush_at);
      rst = (k == rst_at);
      #1;
      if (!busy_o) begin
        finished = 1'b1;
        break;
      end
      if (hold_flag_o) hc++;
    end
    if (!finished) begin
      n_checks++;
      $display("FAIL op_timeout: busy_o still 1 after %0d cycles, required 0", XLEN + 4);
    end
    check("hold_cycles", 32'(hc), 32'(exp_hc));
    if (aborted) begin
      check("abort_hold", 32'(hold_flag_o), 32'h0);
      check("abort_wr_en", 32'(rd_wr_en_o), 32'h0);
      if (rst_at >= 0) begin
        check("rst_rd_data", rd_data_o, 32'h0);
        check("rst_rd_addr", 32'(rd_addr_o), 32'h0);
      end
    end
  endtask

  task automatic do16(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] exp);
    start16 = 1'b1; op16 = op; a16 = a; b16 = b; rd16 = 5'd9;
    #1;
    check("f16_hold_issue", 32'(hold16), 32'h1);
    @(negedge clk);
    start16 = 1'b0;
    #1;
    check("f16_wr_en", 32'(wr16), 32'h1);
    check("f16_rd_data", 32'(rddata16), 32'(exp));
    check("f16_hold_done", 32'(hold16), 32'h0);
    @(negedge clk);
    #1;
    check("f16_idle", 32'(busy16), 32'h0);
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b0; op_i = '0; rs1_data_i = '0; rs2_data_i = '0;
    rd_addr_i = '0; flush_i = 1'b0;
    start16 = 1'b0; op16 = '0; a16 = '0; b16 = '0; rd16 = '0; flush16 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_busy", 32'(busy_o), 32'h0);
    check("reset_hold", 32'(hold_flag_o), 32'h0);
    check("reset_wr_en", 32'(rd_wr_en_o), 32'h0);
    check("reset_rd_data", rd_data_o, 32'h0);
    check("reset_rd_addr", 32'(rd_addr_o), 32'h0);

    do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, -1, -1, -1);
    do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, -1, -1, -1);
    do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, -1, -1, -1);
    do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, -1, -1, -1);
    do_op(3'd4, 32'hFFFF_FFEC, 32'd3, 5'd9, -1, -1, -1);
    do_op(3'd6, 32'hFFFF_FFEC, 32'd3, 5'd10, -1, -1, -1);
    do_op(3'd5, 32'd20, 32'd3, 5'd11, -1, -1, -1);
    do_op(3'd7, 32'd20, 32'd3, 5'd12, -1, -1, -1);
    do_op(3'd4, 32'd5, 32'd0, 5'd13, -1, -1, -1);
    do_op(3'd6, 32'd5, 32'd0, 5'd14, -1, -1, -1);
    do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, -1, -1, -1);
    do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, -1, -1, -1);
    do_op(3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, -1, -1, -1);
    do_op(3'd0, 32'd123, 32'd456, 5'd0, -1, -1, -1);

    do_op(3'd4, 32'd1000, 32'd7, 5'd3, 10, -1, -1);
    do_op(3'd4, 32'hDEAD_BEEF, 32'd12345, 5'd4, -1, -1, 5);
    do_op(3'd3, 32'h1234_5678, 32'h9ABC_DEF0, 5'd18, -1, 5, -1);
    do_op(3'd4, 32'd5, 32'd0, 5'd19, 1, -1, -1);

    // Issue masked by a simultaneous flush.
    start_i = 1'b1; flush_i = 1'b1; op_i = 3'd4; rs1_data_i = 32'd9; rs2_data_i = 32'd2;
    #1;
    check("flush_issue_hold", 32'(hold_flag_o), 32'h0);
    @(negedge clk);
    start_i = 1'b0; flush_i = 1'b0;
    #1;
    check("flush_issue_busy", 32'(busy_o), 32'h0);

    for (int i = 0; i < 40; i++)
      do_op(3'($urandom_range(0, 7)), pick(), pick(), 5'($urandom), -1, -1, -1);

    do16(3'd0, 16'h0100, 16'h0100, 16'h0000);
    do16(3'd3, 16'h0100, 16'h0100, 16'h0001);
    do16(3'd1, 16'hFFFF, 16'hFFFF, 16'h0000);
    do16(3'd2, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    for (int i = 0; i < 8; i++) begin
      logic [2:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      op = 3'($urandom_range(0, 3));
      a = 16'($urandom);
      b = 16'($urandom);
      do16(op, a, b, ref16(op, a, b));
    end

    repeat (3) @(negedge clk);
    #3;
    check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
